// File: rtl/audio_packet_parser.sv
// Host packet parser: pops FIFO bytes, decodes SYNC/CMD/FORMAT/DATA/STOP packets
// and presents assembled stereo PCM frames on a registered valid/ready interface.
//
// state  | meaning
// SYNC   | hunting for SYNC_BYTE; other bytes dropped
// CMD    | next byte selects FORMAT, DATA or STOP
// FMT    | format byte: rate family, depth, reserved bits
// LEN    | frame count of the DATA packet
// SAMPLE | collecting L then R bytes, little-endian per channel
// EMIT   | frame presented, waiting for sample_ready_i
module audio_packet_parser #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter logic [7:0] MAX_ERR   = 8'hFF
) (
  input  logic        clk_i,
  input  logic        reset_i,
  output logic        rd_in_fifo_en_o,
  input  logic        rd_in_fifo_empty_i,
  input  logic [7:0]  rd_in_fifo_data_i,
  output logic        sample_valid_o,
  input  logic        sample_ready_i,
  output logic [23:0] sample_left_o,
  output logic [23:0] sample_right_o,
  output logic        stream_active_o,
  output logic        rate_family_o,
  output logic        depth24_o,
  output logic        err_pulse_o,
  output logic [7:0]  err_count_o
);

  localparam logic [2:0] S_SYNC   = 3'd0;
  localparam logic [2:0] S_CMD    = 3'd1;
  localparam logic [2:0] S_FMT    = 3'd2;
  localparam logic [2:0] S_LEN    = 3'd3;
  localparam logic [2:0] S_SAMPLE = 3'd4;
  localparam logic [2:0] S_EMIT   = 3'd5;

  logic [2:0]  state;
  logic        byte_pend;
  logic [7:0]  frame_cnt;
  logic [2:0]  byte_idx;
  logic [23:0] left_acc;
  logic [23:0] right_acc;
  logic [2:0]  last_left;
  logic [2:0]  last_idx;
  logic        err;
  logic [7:0]  in_byte;

  assign in_byte   = rd_in_fifo_data_i;
  assign last_left = depth24_o ? 3'd2 : 3'd1;
  assign last_idx  = depth24_o ? 3'd5 : 3'd3;

  // Gated by reset so no byte is popped and lost while the block is held in reset.
  assign rd_in_fifo_en_o = ~reset_i & ~rd_in_fifo_empty_i & ~byte_pend & (state != S_EMIT);

  always_comb begin
    err = 1'b0;
    if (byte_pend) begin
      case (state)
        S_CMD: err = !((in_byte == 8'h01) || (in_byte == 8'h03) ||
                       ((in_byte == 8'h02) && stream_active_o));
        S_FMT: err = (in_byte[7:2] != 6'd0);
        S_LEN: err = (in_byte == 8'd0);
        default: err = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state           <= S_SYNC;
      byte_pend       <= 1'b0;
      frame_cnt       <= 8'd0;
      byte_idx        <= 3'd0;
      left_acc        <= 24'd0;
      right_acc       <= 24'd0;
      sample_valid_o  <= 1'b0;
      sample_left_o   <= 24'd0;
      sample_right_o  <= 24'd0;
      stream_active_o <= 1'b0;
      rate_family_o   <= 1'b0;
      depth24_o       <= 1'b0;
      err_pulse_o     <= 1'b0;
      err_count_o     <= 8'd0;
    end else begin
      byte_pend   <= rd_in_fifo_en_o;
      err_pulse_o <= err;
      if (err && (err_count_o != MAX_ERR))
        err_count_o <= err_count_o + 8'd1;

      case (state)
        S_SYNC: if (byte_pend && (in_byte == SYNC_BYTE)) state <= S_CMD;
        S_CMD: if (byte_pend) begin
          state <= S_SYNC;
          if (in_byte == 8'h01) state <= S_FMT;
          else if ((in_byte == 8'h02) && stream_active_o) state <= S_LEN;
          else if (in_byte == 8'h03) stream_active_o <= 1'b0;
        end
        S_FMT: if (byte_pend) begin
          state <= S_SYNC;
          if (in_byte[7:2] == 6'd0) begin
            rate_family_o   <= in_byte[0];
            depth24_o       <= in_byte[1];
            stream_active_o <= 1'b1;
          end
        end
        S_LEN: if (byte_pend) begin
          if (in_byte == 8'd0) begin
            state <= S_SYNC;
          end else begin
            frame_cnt <= in_byte;
            byte_idx  <= 3'd0;
            state     <= S_SAMPLE;
          end
        end
        S_SAMPLE: if (byte_pend) begin
          // First byte of a channel clears the lower lanes so 16-bit samples get [7:0] = 0.
          if (byte_idx <= last_left)
            left_acc <= (byte_idx == 3'd0) ? {in_byte, 16'd0} : {in_byte, left_acc[23:8]};
          else
            right_acc <= (byte_idx == last_left + 3'd1) ? {in_byte, 16'd0}
                                                         : {in_byte, right_acc[23:8]};
          if (byte_idx == last_idx) begin
            sample_left_o  <= left_acc;
            sample_right_o <= {in_byte, right_acc[23:8]};
            sample_valid_o <= 1'b1;
            state          <= S_EMIT;
          end else begin
            byte_idx <= byte_idx + 3'd1;
          end
        end
        S_EMIT: if (sample_ready_i) begin
          sample_valid_o <= 1'b0;
          frame_cnt      <= frame_cnt - 8'd1;
          byte_idx       <= 3'd0;
          state          <= (frame_cnt == 8'd1) ? S_SYNC : S_SAMPLE;
        end
        default: state <= S_SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_packet_parser.sv
// Self-checking bench for audio_packet_parser: FIFO model, frame scoreboard,
// table-driven FORMAT+DATA vectors and hand-written error/stall/reset sequences.
module tb_audio_packet_parser;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rd_en;
  logic        empty = 1'b1;
  logic [7:0]  fifo_data = 8'd0;
  logic        valid;
  logic        ready = 1'b1;
  logic [23:0] left, right;
  logic        active, rate, d24;
  logic        err_pulse;
  logic [7:0]  err_count;

  audio_packet_parser dut (
    .clk_i(clk), .reset_i(reset),
    .rd_in_fifo_en_o(rd_en), .rd_in_fifo_empty_i(empty), .rd_in_fifo_data_i(fifo_data),
    .sample_valid_o(valid), .sample_ready_i(ready),
    .sample_left_o(left), .sample_right_o(right),
    .stream_active_o(active), .rate_family_o(rate), .depth24_o(d24),
    .err_pulse_o(err_pulse), .err_count_o(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
  } frame_t;

  typedef struct {
    logic        d24;
    logic        rate;
    logic [23:0] l;
    logic [23:0] r;
  } vec_t;

  logic [7:0] byte_q[$];
  frame_t     exp_q[$];
  logic       rand_stall = 1'b0;
  int n_cmp = 0, n_bad = 0;
  int viol = 0, emit_pop = 0, stab = 0, pulses = 0;
  logic        prev_valid = 1'b0, prev_hs = 1'b0;
  logic [23:0] prev_l = 24'd0, prev_r = 24'd0;
  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // FIFO model: data appears the cycle after a pop.
  always @(posedge clk) begin
    if (rd_en && byte_q.size() > 0) fifo_data <= byte_q.pop_front();
  end

  always @(posedge clk) begin
    #2;
    empty = (rand_stall && ($urandom_range(0, 1) == 1)) || (byte_q.size() == 0);
  end

  always @(negedge clk) begin
    frame_t f;
    if (rd_en && empty) viol++;
    if (rd_en && valid) emit_pop++;
    if (err_pulse) pulses++;
    if (valid && prev_valid && !prev_hs && ((left != prev_l) || (right != prev_r))) stab++;
    if (valid && ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_frame: got %h/%h expected none", left, right);
      end else begin
        f = exp_q.pop_front();
        check("frame_left", {8'd0, left}, {8'd0, f.l});
        check("frame_right", {8'd0, right}, {8'd0, f.r});
      end
    end
    prev_valid = valid;
    prev_hs    = valid && ready;
    prev_l     = left;
    prev_r     = right;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    pulses = 0;
  endtask

  task automatic push(input logic [7:0] b);
    byte_q.push_back(b);
  endtask

  task automatic send_fmt(input logic dd, input logic rr);
    push(8'hA5); push(8'h01); push({6'd0, dd, rr});
  endtask

  task automatic push_chan(input logic dd, input logic [23:0] v);
    if (dd) begin
      push(v[7:0]); push(v[15:8]); push(v[23:16]);
    end else begin
      push(v[15:8]); push(v[23:16]);
    end
  endtask

  task automatic send_frame(input logic dd, input logic [23:0] l, input logic [23:0] r);
    frame_t f;
    push(8'hA5); push(8'h02); push(8'h01);
    push_chan(dd, l);
    push_chan(dd, r);
    f.l = dd ? l : {l[23:8], 8'h00};
    f.r = dd ? r : {r[23:8], 8'h00};
    exp_q.push_back(f);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (!((byte_q.size() == 0) && (exp_q.size() == 0) && !valid) && k < 4000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 4000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL idle_timeout: got %0d bytes left expected 0", byte_q.size());
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic run_table();
    for (int i = 0; i < 6; i++) begin
      send_fmt(tbl[i].d24, tbl[i].rate);
      send_frame(tbl[i].d24, tbl[i].l, tbl[i].r);
      wait_idle();
      check("tbl_rate", {31'd0, rate}, {31'd0, tbl[i].rate});
      check("tbl_depth", {31'd0, d24}, {31'd0, tbl[i].d24});
      check("tbl_active", {31'd0, active}, 32'd1);
    end
  endtask

  initial begin
    frame_t f;
    int k;
    tbl[0] = '{d24: 1'b1, rate: 1'b0, l: 24'h341200, r: 24'h785600};
    tbl[1] = '{d24: 1'b1, rate: 1'b1, l: 24'h030201, r: 24'h060504};
    tbl[2] = '{d24: 1'b0, rate: 1'b0, l: 24'h123456, r: 24'hABCDEF};
    tbl[3] = '{d24: 1'b0, rate: 1'b1, l: 24'hA5A5A5, r: 24'h00A500};
    tbl[4] = '{d24: 1'b1, rate: 1'b0, l: 24'hA5A5A5, r: 24'h800000};
    tbl[5] = '{d24: 1'b0, rate: 1'b0, l: 24'h7FFF00, r: 24'h800100};

    repeat (3) tick();
    @(negedge clk);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_active", {31'd0, active}, 32'd0);
    check("rst_en", {31'd0, rd_en}, 32'd0);
    check("rst_errcnt", {24'd0, err_count}, 32'd0);
    check("rst_left", {8'd0, left}, 32'd0);
    tick();
    reset = 1'b0;

    run_table();

    // Two-frame 24-bit packet with the consumer stalled on the first frame.
    ready = 1'b0;
    send_fmt(1'b1, 1'b1);
    push(8'hA5); push(8'h02); push(8'h02);
    for (int i = 1; i <= 6; i++) push(8'(i));
    for (int i = 10; i <= 15; i++) push(8'(i));
    f.l = 24'h030201; f.r = 24'h060504; exp_q.push_back(f);
    f.l = 24'h0C0B0A; f.r = 24'h0F0E0D; exp_q.push_back(f);
    k = 0;
    while (!valid && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("stall_valid_seen", {31'd0, valid}, 32'd1);
    repeat (10) tick();
    @(negedge clk);
    check("stall_left_held", {8'd0, left}, 32'h030201);
    check("stall_right_held", {8'd0, right}, 32'h060504);
    tick();
    ready = 1'b1;
    wait_idle();

    // DATA before FORMAT, stray byte, unknown command.
    do_reset();
    push(8'hA5); push(8'h02); push(8'h05); push(8'hA5); push(8'h07);
    wait_idle();
    check("err_cnt_nofmt", {24'd0, err_count}, 32'd2);
    check("err_pulses_nofmt", pulses, 32'd2);
    check("err_active_nofmt", {31'd0, active}, 32'd0);

    // Reserved format bits, then zero-length DATA, then STOP.
    do_reset();
    send_fmt(1'b1, 1'b0);
    byte_q[byte_q.size() - 1] = 8'h04;
    wait_idle();
    check("resv_errcnt", {24'd0, err_count}, 32'd1);
    check("resv_depth_kept", {31'd0, d24}, 32'd0);
    check("resv_active", {31'd0, active}, 32'd0);
    send_fmt(1'b0, 1'b1);
    push(8'hA5); push(8'h02); push(8'h00);
    wait_idle();
    check("len0_errcnt", {24'd0, err_count}, 32'd2);
    check("len0_rate_kept", {31'd0, rate}, 32'd1);
    check("len0_active", {31'd0, active}, 32'd1);
    push(8'hA5); push(8'h03);
    wait_idle();
    check("stop_active", {31'd0, active}, 32'd0);
    check("stop_errcnt", {24'd0, err_count}, 32'd2);

    // Error counter saturation.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      push(8'hA5); push(8'h07);
    end
    wait_idle();
    check("sat_errcnt", {24'd0, err_count}, 32'hFF);
    check("sat_pulses", pulses, 32'd300);

    // Reset in the middle of a 24-bit frame.
    do_reset();
    send_fmt(1'b1, 1'b0);
    push(8'hA5); push(8'h02); push(8'h01);
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    k = 0;
    while (byte_q.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    repeat (4) tick();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_active", {31'd0, active}, 32'd0);
    check("midrst_depth", {31'd0, d24}, 32'd0);
    check("midrst_valid", {31'd0, valid}, 32'd0);
    tick();
    reset = 1'b0;
    send_fmt(1'b0, 1'b0);
    send_frame(1'b0, 24'h556677, 24'h8899AA);
    wait_idle();
    check("postrst_active", {31'd0, active}, 32'd1);

    // Random empty toggling with the full vector table.
    rand_stall = 1'b1;
    run_table();
    rand_stall = 1'b0;

    check("pop_while_empty", viol, 32'd0);
    check("pop_during_emit", emit_pop, 32'd0);
    check("emit_data_stable", stab, 32'd0);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
